// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: shared ALU operation classes, ALU codes and funct7 constants for the RV32I datapath.
package alu_ctrl_pkg;
    localparam logic [1:0] LOADSTORE = 2'b00;
    localparam logic [1:0] BRANCH    = 2'b01;
    localparam logic [1:0] RTYPE     = 2'b10;
    localparam logic [1:0] ITYPE     = 2'b11;
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_SLL  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [6:0] F7_BASE = 7'h00;
    localparam logic [6:0] F7_ALT  = 7'h20;
endpackage

// File: rtl/alu_control_unit_if.sv
// alu_control_unit_if: instruction-field inputs and registered control outputs of the ALU-control decoder.
interface alu_control_unit_if;
    logic [6:0] i_Funct7;
    logic [2:0] i_Funct3;
    logic [1:0] i_ALUOp;
    logic [3:0] o_ALUControlLines;
    logic       o_Illegal;
    modport master (output i_Funct7, i_Funct3, i_ALUOp, input o_ALUControlLines, o_Illegal);
    modport slave  (input i_Funct7, i_Funct3, i_ALUOp, output o_ALUControlLines, o_Illegal);
endinterface

// File: rtl/alu_ctrl_decode.sv
// alu_ctrl_decode: combinational ALUOp/funct3/funct7 to ALU code decode with unsupported-funct7 detection.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [1:0] alu_op_i,
    input  logic [2:0] funct3_i,
    input  logic [6:0] funct7_i,
    output logic [3:0] alu_ctrl_o,
    output logic       illegal_o
);
    logic [3:0] r_code;
    logic       alt;
    logic       f7_bad;
    always_comb begin
        alt    = funct7_i[5];
        f7_bad = (funct7_i != F7_BASE) && (funct7_i != F7_ALT);
        case (funct3_i)
            3'b000:  r_code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  r_code = ALU_SLL;
            3'b010:  r_code = ALU_SLT;
            3'b011:  r_code = ALU_SLTU;
            3'b100:  r_code = ALU_XOR;
            3'b101:  r_code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  r_code = ALU_OR;
            default: r_code = ALU_AND;
        endcase
        // I-type has no SUBI: funct7 of an ADDI is immediate bits, not an opcode modifier
        alu_ctrl_o = (alu_op_i == LOADSTORE) ? ALU_ADD :
                     (alu_op_i == BRANCH) ? ALU_SUB :
                     (alu_op_i == ITYPE && funct3_i == 3'b000) ? ALU_ADD : r_code;
        illegal_o  = f7_bad && ((alu_op_i == RTYPE) ||
                     (alu_op_i == ITYPE && (funct3_i == 3'b001 || funct3_i == 3'b101)));
    end
endmodule

// File: rtl/alu_control_unit.sv
// alu_control_unit: registered ALU-control decoder; outputs valid one clock after inputs are sampled.
module alu_control_unit
    import alu_ctrl_pkg::*;
(
    input  logic i_Clk,
    input  logic i_Rst,
    alu_control_unit_if.slave bus
);
    logic [3:0] code_d, code_q;
    logic       ill_d, ill_q;
    alu_ctrl_decode u_decode (
        .alu_op_i   (bus.i_ALUOp),
        .funct3_i   (bus.i_Funct3),
        .funct7_i   (bus.i_Funct7),
        .alu_ctrl_o (code_d),
        .illegal_o  (ill_d)
    );
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            code_q <= ALU_ADD;
            ill_q  <= 1'b0;
        end else begin
            code_q <= code_d;
            ill_q  <= ill_d;
        end
    end
    assign bus.o_ALUControlLines = code_q;
    assign bus.o_Illegal         = ill_q;
endmodule

// File: tb/tb_alu_control_unit.sv
// tb_alu_control_unit: table-driven directed checks of the registered ALU-control decoder.
module tb_alu_control_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [3:0] code;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    alu_control_unit_if bus ();
    alu_control_unit dut (.i_Clk(clk), .i_Rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] code, input logic ill);
        n_cmp++;
        if (bus.o_ALUControlLines !== code || bus.o_Illegal !== ill) begin
            n_bad++;
            $display("FAIL %s: got code=%b ill=%b, want code=%b ill=%b",
                     name, bus.o_ALUControlLines, bus.o_Illegal, code, ill);
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus.i_ALUOp  = op;
        bus.i_Funct3 = f3;
        bus.i_Funct7 = f7;
    endtask

    task automatic add(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [3:0] code, input logic ill);
        vec_t v;
        v.op = op; v.f3 = f3; v.f7 = f7; v.code = code; v.ill = ill;
        vecs.push_back(v);
    endtask

    initial begin
        logic [3:0] r_tab [8];
        r_tab = '{4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
        for (int i = 0; i < 8; i++) begin
            add(2'b00, 3'(i), 7'h00, 4'b0010, 1'b0);
            add(2'b00, 3'(i), 7'h20, 4'b0010, 1'b0);
            add(2'b01, 3'(i), 7'h00, 4'b0110, 1'b0);
            add(2'b01, 3'(i), 7'h20, 4'b0110, 1'b0);
            add(2'b10, 3'(i), 7'h00, r_tab[i], 1'b0);
            add(2'b10, 3'(i), 7'h20, (i == 0) ? 4'b0110 : (i == 5) ? 4'b0111 : r_tab[i], 1'b0);
        end
        add(2'b11, 3'b000, 7'h20, 4'b0010, 1'b0);
        add(2'b11, 3'b101, 7'h20, 4'b0111, 1'b0);
        add(2'b11, 3'b101, 7'h00, 4'b0101, 1'b0);
        add(2'b11, 3'b001, 7'h01, 4'b0100, 1'b1);
        add(2'b11, 3'b101, 7'h01, 4'b0101, 1'b1);
        add(2'b11, 3'b101, 7'h60, 4'b0111, 1'b1);
        add(2'b11, 3'b010, 7'h7f, 4'b1000, 1'b0);
        add(2'b11, 3'b000, 7'h40, 4'b0010, 1'b0);
        add(2'b11, 3'b110, 7'h20, 4'b0001, 1'b0);
        add(2'b10, 3'b000, 7'h01, 4'b0010, 1'b1);
        add(2'b10, 3'b101, 7'h7f, 4'b0111, 1'b1);
        add(2'b10, 3'b010, 7'h40, 4'b1000, 1'b1);
        add(2'b00, 3'b111, 7'h7f, 4'b0010, 1'b0);
        add(2'b01, 3'b011, 7'h01, 4'b0110, 1'b0);

        // reset with R-type SUB inputs present
        drive(2'b10, 3'b000, 7'h20);
        @(posedge clk); #1;
        check("reset_hold", 4'b0010, 1'b0);
        @(posedge clk); #1;
        check("reset_hold2", 4'b0010, 1'b0);
        rst = 1'b0;
        check("pre_first_edge", 4'b0010, 1'b0);
        @(posedge clk); #1;
        check("first_decode", 4'b0110, 1'b0);

        // back-to-back table, new inputs every cycle
        foreach (vecs[i]) begin
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7);
            @(posedge clk); #1;
            check($sformatf("vec%0d", i), vecs[i].code, vecs[i].ill);
        end

        // exact one-cycle latency for an illegal R-type word
        drive(2'b00, 3'b000, 7'h00);
        @(posedge clk); #1;
        check("lat_pre", 4'b0010, 1'b0);
        drive(2'b10, 3'b000, 7'h01);
        #3;
        check("lat_not_yet", 4'b0010, 1'b0);
        @(posedge clk); #1;
        check("lat_ill", 4'b0010, 1'b1);
        drive(2'b10, 3'b101, 7'h20);
        #3;
        check("lat_hold", 4'b0010, 1'b1);
        @(posedge clk); #1;
        check("lat_sra", 4'b0111, 1'b0);

        // mid-stream reset discards the sampled input and clears illegal
        drive(2'b10, 3'b100, 7'h05);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_reset", 4'b0010, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_reset", 4'b0011, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
